wb_ram_scheduler: RTL
=====================

# wb_ram_scheduler

Sequential arbiter that shares the single Wishbone RAM port between the core data port and the interrupt controller port. The grant is held for a whole transaction, so the RAM never switches masters mid-access. Arbitration is round-robin, with interrupt-controller priority while `Irq_pending` is high. A per-transaction watchdog terminates hung accesses with an error acknowledge. The block sits between the core/ctrl Wishbone slaves and the RAM master interface and replaces the purely combinational IRQ mux.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum granted cycles without RAM ack before forced termination; must be ≥1.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Irq_pending`  in  1  ctrl port has priority while high.
- `S_wb_ctrl_addr`/`S_wb_core_addr`  in  `` `ADDR_SIZE ``  requester address.
- `S_wb_ctrl_cs`/`S_wb_core_cs`  in  1  request valid; held until ack.
- `S_wb_ctrl_we`/`S_wb_core_we`  in  1  write enable.
- `S_wb_ctrl_wdata`/`S_wb_core_wdata`  in  `` `WORD_SIZE ``  write data.
- `S_wb_ctrl_rdata`/`S_wb_core_rdata`  out  `` `WORD_SIZE ``  read data; valid with ack.
- `S_wb_ctrl_ack`/`S_wb_core_ack`  out  1  transaction complete.
- `S_wb_ctrl_err`/`S_wb_core_err`  out  1  timeout termination; asserted only together with ack.
- `M_wb_ram_addr`  out  `` `ADDR_SIZE ``, `M_wb_ram_cs`  out  1, `M_wb_ram_we`  out  1, `M_wb_ram_wdata`  out  `` `WORD_SIZE ``: RAM request.
- `M_wb_ram_rdata`  in  `` `WORD_SIZE ``, `M_wb_ram_ack`  in  1: RAM response.
- `Busy`  out  1  high in any GRANT state.

## Operation
- States: IDLE, GRANT_CORE, GRANT_CTRL. Reset: IDLE, `last_grant` = CTRL, watchdog counter = 0.
- IDLE decision, using this cycle's `cs` inputs:
  - Only one requester has `cs` high: grant it.
  - Both high and `Irq_pending` = 1: grant CTRL.
  - Both high and `Irq_pending` = 0: grant the port that is not `last_grant`.
  - Neither high: stay IDLE.
- On a grant, `last_grant` is updated and the counter is cleared.
- In GRANT_x, the M_wb_ram outputs combinationally follow the granted port. The RAM's rdata and ack combinationally drive that port's rdata and ack.
- The non-granted port sees rdata = 0, ack = 0, err = 0.
- In IDLE, all M outputs are 0 and all S rdata/ack/err outputs are 0.
- `Irq_pending` rising during GRANT_CORE does not preempt; ctrl waits for the current transaction to end.
- Exit from GRANT_x to IDLE, whichever occurs first:
  - RAM ack: normal completion, err = 0.
  - Granted `cs` dropped by the requester (abort): `M_wb_ram_cs` = 0 that cycle, no ack to the requester.
  - Watchdog expiry.
- Watchdog:
  - The counter increments each GRANT cycle without RAM ack, saturating at `TIMEOUT_CYCLES`.
  - When the counter equals `TIMEOUT_CYCLES` and there is no RAM ack: `M_wb_ram_cs` is forced to 0, the granted port gets ack = 1, err = 1, rdata = 0, and the next state is IDLE.
  - A RAM ack in the expiry cycle wins and the transaction completes normally.
- Counter width: $clog2(`TIMEOUT_CYCLES`+1).

## Timing
- Grant latency: a request seen in IDLE at edge N is driven to the RAM during cycle N+1.
- Zero-wait RAM: ack in cycle N+1, IDLE in cycle N+2. Each transaction therefore costs at least 2 cycles, including one mandatory turnaround cycle.
- Back-to-back requests from the same port alternate with the other port when both are pending.
- Maximum grant duration is `TIMEOUT_CYCLES`+1 cycles.
- Asynchronous reset mid-transaction: all outputs go to 0 immediately and the state becomes IDLE. Any RAM ack arriving after reset is ignored.

## Test plan
- Core-only read, RAM acks 1 cycle after cs with rdata 0xDEADBEEF -> core_ack = 1 and core_rdata = 0xDEADBEEF in cycle N+1; `Busy` low in cycle N+2; ctrl outputs stay 0 throughout.
- Both ports request continuously with `Irq_pending` = 0 from reset -> grants go core, ctrl, core, ctrl on successive transactions, with one IDLE cycle between each.
- Core granted with a 5-cycle ack delay; `Irq_pending` and ctrl cs rise in grant cycle 2 -> core transaction completes undisturbed; ctrl is granted 2 cycles after core_ack.
- `TIMEOUT_CYCLES` = 4, RAM never acks a ctrl write -> `M_wb_ram_cs` high for 4 cycles and low in the 5th; in the 5th cycle ctrl_ack = 1, ctrl_err = 1, ctrl_rdata = 0; IDLE next.
- Core drops cs in grant cycle 2 (abort) -> `M_wb_ram_cs` = 0 that cycle, core_ack never asserted, IDLE next, a pending ctrl request is granted after that.
- `Rst_n` pulsed low during a granted access -> all outputs 0 asynchronously; after release, the first tie-break grants core.

Source files
------------

// File: rtl/wb_ram_scheduler.sv
// Grant-holding round-robin arbiter sharing one Wishbone RAM port between the
// core data port and the interrupt controller, with a per-transaction watchdog.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_ram_scheduler #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Irq_pending,
  input  logic [`ADDR_SIZE-1:0] S_wb_ctrl_addr,
  input  logic                  S_wb_ctrl_cs,
  input  logic                  S_wb_ctrl_we,
  input  logic [`WORD_SIZE-1:0] S_wb_ctrl_wdata,
  output logic [`WORD_SIZE-1:0] S_wb_ctrl_rdata,
  output logic                  S_wb_ctrl_ack,
  output logic                  S_wb_ctrl_err,
  input  logic [`ADDR_SIZE-1:0] S_wb_core_addr,
  input  logic                  S_wb_core_cs,
  input  logic                  S_wb_core_we,
  input  logic [`WORD_SIZE-1:0] S_wb_core_wdata,
  output logic [`WORD_SIZE-1:0] S_wb_core_rdata,
  output logic                  S_wb_core_ack,
  output logic                  S_wb_core_err,
  output logic [`ADDR_SIZE-1:0] M_wb_ram_addr,
  output logic                  M_wb_ram_cs,
  output logic                  M_wb_ram_we,
  output logic [`WORD_SIZE-1:0] M_wb_ram_wdata,
  input  logic [`WORD_SIZE-1:0] M_wb_ram_rdata,
  input  logic                  M_wb_ram_ack,
  output logic                  Busy
);
  localparam int NUM_PORTS = 2;
  localparam int CORE      = 0;
  localparam int CTRL      = 1;
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic                  cs;
    logic                  we;
    logic [`ADDR_SIZE-1:0] addr;
    logic [`WORD_SIZE-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                  ack;
    logic                  err;
    logic [`WORD_SIZE-1:0] rdata;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, GRANT_CORE, GRANT_CTRL} state_t;

  state_t           state, state_nxt;
  logic             last_ctrl;
  logic [CNT_W-1:0] cnt;
  req_t             req [NUM_PORTS];
  rsp_t             rsp [NUM_PORTS];
  req_t             gnt_req;
  logic             granted, sel, gcs, expire;

  assign req[CORE] = {S_wb_core_cs, S_wb_core_we, S_wb_core_addr, S_wb_core_wdata};
  assign req[CTRL] = {S_wb_ctrl_cs, S_wb_ctrl_we, S_wb_ctrl_addr, S_wb_ctrl_wdata};
  assign {S_wb_core_ack, S_wb_core_err, S_wb_core_rdata} = rsp[CORE];
  assign {S_wb_ctrl_ack, S_wb_ctrl_err, S_wb_ctrl_rdata} = rsp[CTRL];

  assign granted = (state != IDLE);
  assign sel     = (state == GRANT_CTRL);
  assign gnt_req = req[sel];
  assign gcs     = granted & gnt_req.cs;
  // A RAM ack in the final watchdog cycle still completes normally.
  assign expire  = gcs & (cnt == CNT_MAX) & ~M_wb_ram_ack;

  assign M_wb_ram_cs    = gcs & ~expire;
  assign M_wb_ram_we    = granted & gnt_req.we;
  assign M_wb_ram_addr  = granted ? gnt_req.addr  : '0;
  assign M_wb_ram_wdata = granted ? gnt_req.wdata : '0;
  assign Busy           = granted;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    logic own;
    // An aborted requester (cs dropped) gets nothing, even if the RAM acks late.
    assign own    = gcs & (sel == 1'(p));
    assign rsp[p] = '{ack:   own & (M_wb_ram_ack | expire),
                      err:   own & expire,
                      rdata: (own & ~expire) ? M_wb_ram_rdata : '0};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req[CORE].cs && req[CTRL].cs)
          state_nxt = (Irq_pending || !last_ctrl) ? GRANT_CTRL : GRANT_CORE;
        else if (req[CTRL].cs)
          state_nxt = GRANT_CTRL;
        else if (req[CORE].cs)
          state_nxt = GRANT_CORE;
      end
      GRANT_CORE, GRANT_CTRL: begin
        if (!gcs || M_wb_ram_ack || expire)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      last_ctrl <= 1'b1;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        if (state_nxt != IDLE)
          last_ctrl <= (state_nxt == GRANT_CTRL);
      end else if (!M_wb_ram_ack && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
